adc_sampler: RTL and testbench
==============================

// Module: adc_sampler
// PURPOSE
//  Periodic conversion sequencer and block averager downstream of the ADC SPI interface.
//  Raises start towards the ADC on a fixed sample period and runs the start/is_idle handshake.
//  Captures each 16-bit signed result, forwards it as a raw sample and averages 2**LOG2_AVG
//  samples into one decimated output for the control/DAC path.
// PARAMETERS
//  PERIOD       100  clk cycles between conversion ticks; must be >= HOLD_CYCLES+TIMEOUT+4
//  HOLD_CYCLES  40   cycles adc_start_o stays high after ADC leaves idle (ADC needs >=35)
//  LOG2_AVG     4    log2 of samples per average (1..8)
//  TIMEOUT      16   max cycles to wait for adc_is_idle_i to change before flagging error
// PORTS
//  clk_i           in   1   clock
//  reset_i         in   1   asynchronous reset, active-high
//  enable_i        in   1   1 = run periodic conversions
//  clear_i         in   1   1-cycle pulse: clears error_o, overrun_o, accumulator and count
//  adc_data_i      in   16  signed result from ADC (valid while ADC idle after a conversion)
//  adc_is_idle_i   in   1   ADC idle indicator
//  adc_start_o     out  1   start request to ADC
//  sample_o        out  16  last captured raw sample, signed
//  sample_valid_o  out  1   1-cycle pulse when sample_o updates
//  avg_o           out  16  last block average, signed
//  avg_valid_o     out  1   1-cycle pulse when avg_o updates
//  overrun_o       out  1   sticky: tick arrived while a conversion was in progress
//  error_o         out  1   sticky: handshake timeout
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, period counter 0, accumulator 0, sample count 0.
//  Period counter: counts 0..PERIOD-1 while enable_i=1, tick when it equals PERIOD-1;
//   held at 0 while enable_i=0. First tick PERIOD cycles after enable_i rises.
//  FSM:
//   IDLE:    tick & enable_i -> START.
//   START:   adc_start_o=1; adc_is_idle_i=0 -> HOLD (hold counter=0);
//            TIMEOUT cycles without it -> error_o=1, -> IDLE.
//   HOLD:    adc_start_o=1; after HOLD_CYCLES cycles -> RELEASE.
//   RELEASE: adc_start_o=0; adc_is_idle_i=1 -> CAPTURE;
//            TIMEOUT cycles without it -> error_o=1, -> IDLE.
//   CAPTURE: sample_o<=adc_data_i, sample_valid_o pulses next cycle; accumulate; -> IDLE.
//  adc_start_o is registered and is 1 exactly in START and HOLD.
//  Accumulator: signed, 16+LOG2_AVG bits, sign-extended add of adc_data_i. No overflow possible.
//  On the 2**LOG2_AVG-th sample: avg_o <= (acc+sample) >>> LOG2_AVG (arithmetic, floor toward
//   -inf), avg_valid_o pulses in the same cycle as sample_valid_o; accumulator and count reset.
//  Tick while FSM is not IDLE: tick dropped, overrun_o=1; in-flight conversion unaffected.
//  enable_i falling mid-conversion: current conversion completes and is captured; no new start.
//  clear_i: clears flags, accumulator and count next cycle; does not abort in-flight conversion.
//   If clear_i coincides with CAPTURE: the capture is kept and the accumulator restarts at that
//   sample. If clear_i coincides with an error/overrun event: the flag is set (set wins).
//  Async reset mid-conversion: adc_start_o drops immediately and the FSM returns to IDLE.
//   The partial average is discarded.
// TESTING
//  1 Reset then enable_i=1, ADC model returns 16'h0100 -> first adc_start_o at cycle PERIOD,
//    sample_o=256 with 1 sample_valid_o pulse per PERIOD cycles.
//  2 LOG2_AVG=2, samples 10,20,30,-4 -> avg_o=14 on the 4th sample_valid_o; samples
//    -1,-1,-1,-2 -> avg_o=-2.
//  3 Samples all 16'h7FFF, then all 16'h8000 (LOG2_AVG=4) -> avg_o=32767, then -32768,
//    no wrap.
//  4 ADC model never drops is_idle -> error_o=1 after TIMEOUT cycles in START, adc_start_o=0;
//    clear_i -> error_o=0.
//  5 PERIOD=30 with HOLD_CYCLES=40 -> overrun_o=1, conversions still complete at 1 per 2 ticks.
//  6 enable_i low during HOLD -> that sample is captured, no further adc_start_o;
//    reset_i during HOLD -> adc_start_o=0 asynchronously and all outputs 0.

Source files
------------

// File: rtl/adc_sampler.sv
// Periodic ADC conversion sequencer: drives the start/is_idle handshake on a fixed
// tick, captures each signed result and emits a block average of 2**LOG2_AVG samples.
module adc_sampler #(
    parameter int PERIOD      = 100,
    parameter int HOLD_CYCLES = 40,
    parameter int LOG2_AVG    = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        clear_i,
    input  logic [15:0] adc_data_i,
    input  logic        adc_is_idle_i,
    output logic        adc_start_o,
    output logic [15:0] sample_o,
    output logic        sample_valid_o,
    output logic [15:0] avg_o,
    output logic        avg_valid_o,
    output logic        overrun_o,
    output logic        error_o
);
    localparam int CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int TMAX = (HOLD_CYCLES > TIMEOUT) ? HOLD_CYCLES : TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int AW   = 16 + LOG2_AVG;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_HOLD,
        S_RELEASE,
        S_CAPTURE
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]       per_cnt;
    logic                tick;
    logic [TW-1:0]       tmr;
    logic                timed_out;
    logic                hold_done;
    logic                err_evt;
    logic                capture;
    logic                overrun_evt;
    logic [LOG2_AVG-1:0] avg_cnt;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sample_ext;
    logic signed [AW-1:0] acc_sum;

    assign tick        = enable_i && (per_cnt == CW'(PERIOD - 1));
    assign timed_out   = (tmr == TW'(TIMEOUT - 1));
    assign hold_done   = (tmr == TW'(HOLD_CYCLES - 1));
    assign overrun_evt = tick && (state != S_IDLE);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            per_cnt <= '0;
        end else if (!enable_i || tick) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        err_evt    = 1'b0;
        capture    = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick) state_next = S_START;
            end
            S_START: begin
                if (!adc_is_idle_i) begin
                    state_next = S_HOLD;
                end else if (timed_out) begin
                    err_evt    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_HOLD: begin
                if (hold_done) state_next = S_RELEASE;
            end
            S_RELEASE: begin
                if (adc_is_idle_i) begin
                    state_next = S_CAPTURE;
                end else if (timed_out) begin
                    err_evt    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_CAPTURE: begin
                capture    = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // tmr counts cycles spent in the current state; restarts on every transition
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= S_IDLE;
            tmr         <= '0;
            adc_start_o <= 1'b0;
        end else begin
            state       <= state_next;
            tmr         <= (state_next != state || state == S_IDLE) ? '0 : tmr + 1'b1;
            adc_start_o <= (state_next == S_START) || (state_next == S_HOLD);
        end
    end

    assign sample_ext = {{LOG2_AVG{adc_data_i[15]}}, adc_data_i};
    assign acc_sum    = acc + sample_ext;

    // Top 16 bits of the widened sum are exactly floor(sum / 2**LOG2_AVG)
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sample_o       <= '0;
            sample_valid_o <= 1'b0;
            avg_o          <= '0;
            avg_valid_o    <= 1'b0;
            acc            <= '0;
            avg_cnt        <= '0;
        end else begin
            sample_valid_o <= 1'b0;
            avg_valid_o    <= 1'b0;
            if (capture) begin
                sample_o       <= adc_data_i;
                sample_valid_o <= 1'b1;
                if (clear_i) begin
                    acc     <= sample_ext;
                    avg_cnt <= LOG2_AVG'(1);
                end else if (&avg_cnt) begin
                    avg_o       <= acc_sum[AW-1:LOG2_AVG];
                    avg_valid_o <= 1'b1;
                    acc         <= '0;
                    avg_cnt     <= '0;
                end else begin
                    acc     <= acc_sum;
                    avg_cnt <= avg_cnt + 1'b1;
                end
            end else if (clear_i) begin
                acc     <= '0;
                avg_cnt <= '0;
            end
        end
    end

    // Sticky flags: a same-cycle event beats clear_i
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            error_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            if (err_evt) error_o <= 1'b1;
            else if (clear_i) error_o <= 1'b0;
            if (overrun_evt) overrun_o <= 1'b1;
            else if (clear_i) overrun_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_sampler.sv
// Bench for adc_sampler: behavioural ADC responder, sample/average scoreboard and
// directed scenarios for period, averaging, saturation values, timeout, overrun and reset.
module tb_adc_sampler;
    localparam int P  = 20;
    localparam int H  = 8;
    localparam int L  = 2;
    localparam int TO = 8;
    localparam int N  = 1 << L;

    logic        clk = 1'b0;
    logic        reset, enable, clear, idle;
    logic [15:0] data;
    logic        adc_start_o, sample_valid_o, avg_valid_o, overrun_o, error_o;
    logic [15:0] sample_o, avg_o;

    int checks = 0;
    int errors = 0;

    // ADC responder knobs and bookkeeping
    int          d1 = 1, d2 = 1;
    bit          never_drop = 1'b0;
    bit          rand_delay = 1'b0;
    int          rise_cnt = 0;
    logic [15:0] data_q[$];
    int          exp_q[$];
    int          starts = 0, pulses = 0;

    adc_sampler #(.PERIOD(P), .HOLD_CYCLES(H), .LOG2_AVG(L), .TIMEOUT(TO)) dut (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .clear_i(clear),
        .adc_data_i(data), .adc_is_idle_i(idle), .adc_start_o(adc_start_o),
        .sample_o(sample_o), .sample_valid_o(sample_valid_o), .avg_o(avg_o),
        .avg_valid_o(avg_valid_o), .overrun_o(overrun_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int floor_div(input int s, input int d);
        int q;
        q = s / d;
        if ((s % d != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    // ADC: leaves idle d1 cycles after start is seen, returns to idle with data d2
    // cycles after start is released
    initial begin
        int phase, cnt;
        phase = 0;
        cnt   = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                phase = 0;
                idle  = 1'b1;
                continue;
            end
            case (phase)
                0: if (adc_start_o && !never_drop) begin
                    phase = 1;
                    cnt   = 0;
                    if (rand_delay) begin
                        d1 = $urandom_range(0, 2);
                        d2 = $urandom_range(0, 2);
                    end
                end
                1: if (!adc_start_o) phase = 0;
                   else if (cnt >= d1) begin idle = 1'b0; phase = 2; end
                   else cnt++;
                2: if (!adc_start_o) begin phase = 3; cnt = 0; end
                3: if (cnt >= d2) begin
                    data = (data_q.size() > 0) ? data_q.pop_front() : 16'($urandom);
                    idle = 1'b1;
                    exp_q.push_back(int'($signed(data)));
                    rise_cnt++;
                    phase = 0;
                end else cnt++;
                default: phase = 0;
            endcase
        end
    end

    // Scoreboard: every captured sample, and the floor average of every N samples
    initial begin
        bit c, prev_start;
        int sum, n, e;
        prev_start = 1'b0;
        sum = 0;
        n   = 0;
        forever begin
            @(posedge clk);
            c = clear;
            @(negedge clk);
            if (reset) begin
                sum = 0; n = 0; prev_start = 1'b0;
                exp_q.delete();
                continue;
            end
            if (adc_start_o && !prev_start) starts++;
            prev_start = adc_start_o;
            if (sample_valid_o) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    chk("sample_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sample", int'($signed(sample_o)), e);
                    if (c) begin
                        sum = e; n = 1;
                        chk("avg_valid_on_clear", avg_valid_o, 0);
                    end else begin
                        sum += e; n++;
                        if (n == N) begin
                            chk("avg_valid", avg_valid_o, 1);
                            chk("avg", int'($signed(avg_o)), floor_div(sum, N));
                            sum = 0; n = 0;
                        end else begin
                            chk("avg_valid_early", avg_valid_o, 0);
                        end
                    end
                end
            end else begin
                if (c) begin sum = 0; n = 0; end
                if (avg_valid_o) chk("avg_valid_alone", avg_valid_o, 0);
            end
        end
    end

    task automatic wait_pulses(input int target, input string tag);
        int t;
        t = 0;
        while (pulses < target && t < 40 * P) begin
            @(negedge clk);
            t++;
        end
        chk(tag, pulses, target);
    endtask

    task automatic wait_start_rise(input string tag);
        int t;
        bit prev;
        t = 0;
        prev = adc_start_o;
        while (!(adc_start_o && !prev) && t < 10 * P) begin
            prev = adc_start_o;
            @(negedge clk);
            t++;
        end
        chk(tag, adc_start_o, 1);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic quiesce();
        enable = 1'b0;
        repeat (2 * P) @(negedge clk);
        pulse_clear();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, s0;
        reset = 1'b1; enable = 1'b0; clear = 1'b0; idle = 1'b1; data = '0;
        repeat (3) @(negedge clk);
        chk("rst_start", adc_start_o, 0);
        chk("rst_sample", sample_o, 0);
        chk("rst_svalid", sample_valid_o, 0);
        chk("rst_avg", avg_o, 0);
        chk("rst_avalid", avg_valid_o, 0);
        chk("rst_overrun", overrun_o, 0);
        chk("rst_error", error_o, 0);
        reset = 1'b0;
        @(negedge clk);

        // Period: first start on the P-th edge after enable, then one per P cycles
        repeat (6) data_q.push_back(16'h0100);
        enable = 1'b1;
        for (int k = 1; k <= P; k++) begin
            @(negedge clk);
            if (k == P - 1) chk("start_early", adc_start_o, 0);
            if (k == P)     chk("first_start", adc_start_o, 1);
        end
        s0 = starts; p0 = pulses;
        repeat (3 * P) @(negedge clk);
        chk("start_rate", starts - s0, 3);
        chk("sample_rate", pulses - p0, 3);
        chk("sample_256", int'($signed(sample_o)), 256);
        quiesce();

        // Block average with floor toward -inf
        data_q = '{16'd10, 16'd20, 16'd30, 16'hFFFC, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE};
        p0 = pulses;
        enable = 1'b1;
        wait_pulses(p0 + 4, "avg_a_wait");
        chk("avg_14", int'($signed(avg_o)), 14);
        wait_pulses(p0 + 8, "avg_b_wait");
        chk("avg_m2", int'($signed(avg_o)), -2);
        quiesce();

        // Full-scale samples do not wrap
        data_q = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
        p0 = pulses;
        enable = 1'b1;
        wait_pulses(p0 + 4, "max_wait");
        chk("avg_max", int'($signed(avg_o)), 32767);
        wait_pulses(p0 + 8, "min_wait");
        chk("avg_min", int'($signed(avg_o)), -32768);
        quiesce();

        // Random data and delays, one clear landing on a capture
        rand_delay = 1'b1;
        p0 = pulses;
        enable = 1'b1;
        wait_pulses(p0 + 5, "rand_a_wait");
        s0 = rise_cnt;
        while (rise_cnt == s0) @(negedge clk);
        @(negedge clk);
        pulse_clear();
        wait_pulses(p0 + 14, "rand_b_wait");
        chk("rand_overrun", overrun_o, 0);
        chk("rand_error", error_o, 0);
        rand_delay = 1'b0;
        quiesce();

        // Handshake timeout in START
        d1 = 1; d2 = 1;
        never_drop = 1'b1;
        enable = 1'b1;
        wait_start_rise("to_start");
        repeat (TO - 1) @(negedge clk);
        chk("to_err_before", error_o, 0);
        chk("to_start_before", adc_start_o, 1);
        @(negedge clk);
        enable = 1'b0;
        chk("to_err", error_o, 1);
        chk("to_start_drop", adc_start_o, 0);
        never_drop = 1'b0;
        repeat (3) @(negedge clk);
        pulse_clear();
        chk("to_err_cleared", error_o, 0);
        quiesce();

        // Slow ADC: every other tick lands mid-conversion
        d1 = 6; d2 = 6;
        enable = 1'b1;
        repeat (3 * P) @(negedge clk);
        chk("ovr_flag", overrun_o, 1);
        s0 = starts; p0 = pulses;
        repeat (8 * P) @(negedge clk);
        chk("ovr_starts", starts - s0, 4);
        chk("ovr_samples", pulses - p0, 4);
        chk("ovr_error", error_o, 0);
        quiesce();
        chk("ovr_cleared", overrun_o, 0);

        // enable dropped during HOLD: that sample still lands, nothing further starts
        d1 = 1; d2 = 1;
        p0 = pulses;
        enable = 1'b1;
        wait_start_rise("en_start");
        repeat (4) @(negedge clk);
        enable = 1'b0;
        wait_pulses(p0 + 1, "en_capture");
        s0 = starts;
        repeat (3 * P) @(negedge clk);
        chk("en_no_start", starts - s0, 0);

        // Async reset during HOLD
        enable = 1'b1;
        wait_start_rise("rst_hold_start");
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_start", adc_start_o, 0);
        chk("arst_sample", sample_o, 0);
        chk("arst_avg", avg_o, 0);
        chk("arst_flags", {overrun_o, error_o}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        data_q = '{16'd100, 16'd100, 16'd100, 16'd100};
        p0 = pulses;
        wait_pulses(p0 + 4, "post_rst_wait");
        chk("post_rst_avg", int'($signed(avg_o)), 100);
        enable = 1'b0;
        repeat (2 * P) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
